if_stage_iq: RTL and testbench

//  Parametrised instruction-fetch stage with multiple outstanding requests and a decoupling instruction queue.

---
 rtl/if_stage_iq.sv | 148 ++++++++++++++
 tb/tb_if_stage_iq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_iq.sv
// Instruction fetch stage: up to MAX_OUTSTANDING SRAM requests in flight,
// with a decoupling instruction queue feeding the ID stage.
module if_stage_iq #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          IQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        fs_flush_pipe,
    input  logic [31:0] ws_to_fs_bus,
    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [64:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int AW = $clog2(IQ_DEPTH);
    localparam int QW = AW + 1;
    localparam int PD = MAX_OUTSTANDING;
    localparam int PW = (PD > 1) ? $clog2(PD) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1) + 1;

    logic [31:0]   fetch_pc;
    logic          adef_stall;
    logic [64:0]   iq_mem [IQ_DEPTH];
    logic [AW-1:0] iq_head;
    logic [AW-1:0] iq_tail;
    logic [QW-1:0] iq_cnt;
    logic [31:0]   pend_mem [PD];
    logic [PW-1:0] pend_head;
    logic [PW-1:0] pend_tail;
    logic [CW-1:0] live;
    logic [CW-1:0] cancel;

    logic        redirect;
    logic [31:0] target;
    logic        iq_room;
    logic        flight_room;
    logic        accept;
    logic        resp_live;
    logic        resp_drop;
    logic        adef_push;
    logic        push;
    logic        pop;
    logic [64:0] push_data;

    function automatic logic [PW-1:0] pnext(input logic [PW-1:0] p);
        return (p == PW'(PD - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        redirect    = fs_flush_pipe | br_taken;
        target      = fs_flush_pipe ? ws_to_fs_bus : br_target;
        // credits: queued entries plus live requests must fit in the IQ
        iq_room     = (32'(iq_cnt) + 32'(live)) < 32'(IQ_DEPTH);
        flight_room = (32'(live) + 32'(cancel)) < 32'(MAX_OUTSTANDING);
        inst_sram_req = !reset && !redirect && !adef_stall
                        && (fetch_pc[1:0] == 2'b00)
                        && iq_room && flight_room;
        accept    = inst_sram_req & inst_sram_addr_ok;
        resp_live = inst_sram_data_ok & (cancel == '0) & !redirect;
        resp_drop = inst_sram_data_ok & (cancel != '0) & !redirect;
        adef_push = !reset && !redirect && !adef_stall
                    && (fetch_pc[1:0] != 2'b00)
                    && (iq_cnt != QW'(IQ_DEPTH));
        push      = resp_live | adef_push;
        push_data = adef_push ? {1'b1, 32'h0, fetch_pc}
                              : {1'b0, inst_sram_rdata, pend_mem[pend_head]};
        fs_to_ds_valid = (iq_cnt != '0) & !redirect;
        pop            = fs_to_ds_valid & ds_allowin;
        fs_to_ds_bus   = iq_mem[iq_head];
    end

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'h2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            iq_mem[iq_tail] <= push_data;
        end
        if (!reset && accept) begin
            pend_mem[pend_tail] <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            adef_stall <= 1'b0;
            iq_head    <= '0;
            iq_tail    <= '0;
            iq_cnt     <= '0;
            pend_head  <= '0;
            pend_tail  <= '0;
            live       <= '0;
            cancel     <= '0;
        end else if (redirect) begin
            // every live request becomes a cancelled one, except a
            // response arriving right now, which is simply discarded
            fetch_pc   <= target;
            adef_stall <= 1'b0;
            iq_head    <= '0;
            iq_tail    <= '0;
            iq_cnt     <= '0;
            pend_head  <= '0;
            pend_tail  <= '0;
            live       <= '0;
            cancel     <= cancel + live - CW'(inst_sram_data_ok);
        end else begin
            if (accept) begin
                fetch_pc  <= fetch_pc + 32'd4;
                pend_tail <= pnext(pend_tail);
            end
            if (resp_live) begin
                pend_head <= pnext(pend_head);
            end
            live <= live + CW'(accept) - CW'(resp_live);
            if (resp_drop) begin
                cancel <= cancel - CW'(1);
            end
            if (adef_push) begin
                adef_stall <= 1'b1;
            end
            if (push) begin
                iq_tail <= iq_tail + AW'(1);
            end
            if (pop) begin
                iq_head <= iq_head + AW'(1);
            end
            iq_cnt <= iq_cnt + QW'(push) - QW'(pop);
        end
    end

endmodule

// File: tb/tb_if_stage_iq.sv
// Directed bench for if_stage_iq: SRAM responder model plus a queue of
// expected ID-stage entries, compared as entries are popped.
module tb_if_stage_iq;

    localparam logic [31:0] RPC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_flush_pipe;
    logic [31:0] ws_to_fs_bus;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [64:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_stage_iq dut (
        .clk               (clk),
        .reset             (reset),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .fs_flush_pipe     (fs_flush_pipe),
        .ws_to_fs_bus      (ws_to_fs_bus),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          t;
    } req_t;

    req_t        sram_q[$];
    logic [64:0] expq[$];
    logic [31:0] model_pc;
    logic [31:0] first_pc;
    logic        want_first;
    logic        last_dok;
    bit          aok_en;
    bit          resp_en;
    int          lat;
    int          cyc;
    int          pops;
    int          acc_count;
    int          acc_first;
    int          pop_first;
    int          passed;
    int          total;

    function automatic logic [31:0] fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle();
        logic        redir;
        logic [31:0] tgt;
        logic [64:0] e;
        inst_sram_addr_ok = aok_en;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'hdeadbeef;
        if (resp_en && sram_q.size() != 0) begin
            if (cyc - sram_q[0].t >= lat) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = fn(sram_q[0].addr);
                void'(sram_q.pop_front());
            end
        end
        last_dok = inst_sram_data_ok;
        #1;
        redir = br_taken | fs_flush_pipe;
        if (redir) chk("redir_valid", 65'(fs_to_ds_valid), 65'(0));
        if (fs_to_ds_valid && ds_allowin) begin
            pops++;
            if (pop_first < 0) pop_first = cyc;
            chk("pop_expected", 65'(expq.size() != 0), 65'(1));
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("pop_entry", fs_to_ds_bus, e);
                if (want_first) begin
                    first_pc   = fs_to_ds_bus[31:0];
                    want_first = 1'b0;
                end
            end
        end
        if (inst_sram_req && inst_sram_addr_ok) begin
            chk("req_addr", 65'(inst_sram_addr), 65'(model_pc));
            expq.push_back({1'b0, fn(model_pc), model_pc});
            sram_q.push_back('{addr: model_pc, t: cyc});
            if (acc_first < 0) acc_first = cyc;
            model_pc = model_pc + 32'd4;
            acc_count++;
        end
        if (redir) begin
            expq.delete();
            tgt      = fs_flush_pipe ? ws_to_fs_bus : br_target;
            model_pc = tgt;
            if (tgt[1:0] != 2'b00) expq.push_back({1'b1, 32'h0, tgt});
            want_first = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic reset_dut();
        reset             = 1'b1;
        br_taken          = 1'b0;
        br_target         = 32'h0;
        fs_flush_pipe     = 1'b0;
        ws_to_fs_bus      = 32'h0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        @(posedge clk);
        #1;
        chk("reset_valid", 65'(fs_to_ds_valid), 65'(0));
        chk("reset_req", 65'(inst_sram_req), 65'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        sram_q.delete();
        expq.delete();
        model_pc   = RPC;
        want_first = 1'b0;
        first_pc   = 32'h0;
        acc_count  = 0;
        acc_first  = -1;
        pop_first  = -1;
        pops       = 0;
        #1;
    endtask

    task automatic drain();
        aok_en     = 1'b0;
        resp_en    = 1'b1;
        ds_allowin = 1'b1;
        run(8);
        chk("drain_exp", 65'(expq.size()), 65'(0));
        chk("drain_sram", 65'(sram_q.size()), 65'(0));
    endtask

    task automatic redirect_br(input logic [31:0] t);
        br_taken  = 1'b1;
        br_target = t;
        cycle();
        br_taken  = 1'b0;
    endtask

    initial begin
        int  p0;
        int  snap;
        bit  found;
        passed = 0;
        total  = 0;
        cyc    = 0;
        lat    = 1;
        aok_en = 1'b0;
        resp_en = 1'b1;
        ds_allowin = 1'b1;

        // streaming fetch, one entry per cycle
        reset_dut();
        chk("tie_wr", 65'(inst_sram_wr), 65'(0));
        chk("tie_size", 65'(inst_sram_size), 65'(2));
        chk("tie_wstrb", 65'(inst_sram_wstrb), 65'(0));
        chk("tie_wdata", 65'(inst_sram_wdata), 65'(0));
        chk("first_req", 65'(inst_sram_req), 65'(1));
        chk("first_addr", 65'(inst_sram_addr), 65'(RPC));
        aok_en = 1'b1;
        run(5);
        p0 = pops;
        run(8);
        chk("throughput", 65'(pops - p0), 65'(8));
        chk("latency", 65'(pop_first - acc_first), 65'(2));
        drain();

        // ID stalled: IQ fills to exactly IQ_DEPTH
        reset_dut();
        ds_allowin = 1'b0;
        aok_en = 1'b1;
        run(10);
        chk("full_accepts", 65'(acc_count), 65'(4));
        chk("full_req", 65'(inst_sram_req), 65'(0));
        chk("full_valid", 65'(fs_to_ds_valid), 65'(1));
        chk("full_head_pc", 65'(fs_to_ds_bus[31:0]), 65'(RPC));
        drain();

        // two in flight, branch cancels both
        reset_dut();
        aok_en  = 1'b1;
        resp_en = 1'b0;
        run(3);
        chk("inflight", 65'(acc_count), 65'(2));
        redirect_br(32'h1c000100);
        resp_en = 1'b1;
        run(10);
        chk("br_first_pc", 65'(first_pc), 65'(32'h1c000100));
        drain();

        // flush and branch together, flush wins
        reset_dut();
        aok_en = 1'b1;
        run(4);
        fs_flush_pipe = 1'b1;
        ws_to_fs_bus  = 32'h1c008000;
        br_taken      = 1'b1;
        br_target     = 32'h1c000200;
        cycle();
        fs_flush_pipe = 1'b0;
        br_taken      = 1'b0;
        run(8);
        chk("flush_first_pc", 65'(first_pc), 65'(32'h1c008000));
        drain();

        // redirect coincident with a response, one other live
        reset_dut();
        lat    = 2;
        aok_en = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (sram_q.size() == 2 && cyc - sram_q[0].t >= lat) found = 1'b1;
            else cycle();
        end
        chk("coinc_setup", 65'(found), 65'(1));
        redirect_br(32'h1c000300);
        chk("coinc_dok", 65'(last_dok), 65'(1));
        run(10);
        chk("coinc_first_pc", 65'(first_pc), 65'(32'h1c000300));
        drain();

        // misaligned target raises ADEF and stalls
        reset_dut();
        lat    = 1;
        aok_en = 1'b1;
        run(3);
        redirect_br(32'h1c000102);
        snap = acc_count;
        run(6);
        chk("adef_noreq", 65'(acc_count), 65'(snap));
        chk("adef_req", 65'(inst_sram_req), 65'(0));
        chk("adef_pc", 65'(first_pc), 65'(32'h1c000102));
        chk("adef_empty", 65'(fs_to_ds_valid), 65'(0));
        redirect_br(32'h1c000400);
        run(6);
        chk("adef_resume_pc", 65'(first_pc), 65'(32'h1c000400));
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
